// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage between the cache and the decoder.
// After reset it reads the reset vector (low byte at 0xFFFC, high byte at
// 0xFFFD), then streams bytes from the cache into a DEPTH-entry FIFO that
// the decoder drains one byte per cycle. A flush empties the FIFO and
// redirects fetch to a branch target.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   cache_hit       - cache holds the byte at fetch_addr (same cycle)
//   cache_data      - byte at fetch_addr, valid with cache_hit
//   flush           - branch taken: empty the queue, fetch from flush_addr
//   flush_addr      - branch target
//   pop             - decoder consumes the head byte this cycle
//   fetch_addr      - address presented to the cache
//   fetch_req       - combinational cache read request
//   byte_out        - head byte
//   byte_pc         - address the head byte was fetched from
//   valid           - queue not empty
//   count           - occupancy 0..DEPTH
//   pc_inc          - registered one-cycle pulse per byte accepted
//   dbg_state       - current fetch state (0 VEC_LO, 1 VEC_HI, 2 RUN)
//
// Handshake: a queue push happens on a rising edge where fetch_req and
// cache_hit are both high in RUN; a pop happens on a rising edge where pop
// and valid are both high. flush overrides both in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cache_hit,
  input  logic [7:0]    cache_data,
  input  logic          flush,
  input  logic [AW-1:0] flush_addr,
  input  logic          pop,
  output logic [AW-1:0] fetch_addr,
  output logic          fetch_req,
  output logic [7:0]    byte_out,
  output logic [AW-1:0] byte_pc,
  output logic          valid,
  output logic [3:0]    count,
  output logic          pc_inc,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [AW-1:0] VEC_LO_ADDR = AW'(16'hFFFC);
  localparam logic [AW-1:0] VEC_HI_ADDR = AW'(16'hFFFD);

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [7:0]    vec_lo_q, vec_lo_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    count_q, count_d;
  logic          pc_inc_q, pc_inc_d;

  logic [7:0]    data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];

  logic full;
  logic push;
  logic do_pop;

  assign full = (count_q == 4'(DEPTH));

  // No bypass: a full queue never requests, even with a pop this cycle.
  // Gated by rst so the request drops the moment reset is asserted.
  always_comb begin
    fetch_req = 1'b0;
    if (!rst) begin
      if (state_q == RUN) fetch_req = !full && !flush;
      else                fetch_req = 1'b1;
    end
  end

  assign push   = (state_q == RUN) && fetch_req && cache_hit;
  assign do_pop = pop && (count_q != 4'd0) && !flush;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    vec_lo_d     = vec_lo_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    pc_inc_d     = 1'b0;
    if (flush) begin
      state_d      = RUN;
      fetch_addr_d = flush_addr;
      head_d       = '0;
      tail_d       = '0;
      count_d      = 4'd0;
    end else begin
      case (state_q)
        VEC_LO: begin
          if (cache_hit) begin
            vec_lo_d     = cache_data;
            fetch_addr_d = VEC_HI_ADDR;
            state_d      = VEC_HI;
          end
        end
        VEC_HI: begin
          if (cache_hit) begin
            fetch_addr_d = AW'({cache_data, vec_lo_q});
            state_d      = RUN;
          end
        end
        RUN: begin
          // Pointers wrap naturally since DEPTH is a power of two.
          if (push) begin
            tail_d       = tail_q + 1'b1;
            fetch_addr_d = fetch_addr_q + 1'b1;
            pc_inc_d     = 1'b1;
          end
          if (do_pop) head_d = head_q + 1'b1;
          count_d = count_q + {3'b000, push} - {3'b000, do_pop};
        end
        default: state_d = VEC_LO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= VEC_LO;
      fetch_addr_q <= VEC_LO_ADDR;
      vec_lo_q     <= 8'h00;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= 4'd0;
      pc_inc_q     <= 1'b0;
      // Storage is cleared so the head outputs are never X after reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= 8'h00;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      vec_lo_q     <= vec_lo_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pc_inc_q     <= pc_inc_d;
      if (push) begin
        data_q[tail_q] <= cache_data;
        pc_q[tail_q]   <= fetch_addr_q;
      end
    end
  end

  assign fetch_addr = fetch_addr_q;
  assign byte_out   = data_q[head_q];
  assign byte_pc    = pc_q[head_q];
  assign valid      = (count_q != 4'd0);
  assign count      = count_q;
  assign pc_inc     = pc_inc_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage sitting between the `cache` and the instruction decoder. It owns the fetch address, loads the reset vector from 0xFFFC/0xFFFD after reset, and streams instruction bytes from the cache into a small FIFO. The decoder pops one byte per cycle together with the address that byte came from. A branch-taken flush empties the queue and redirects fetch.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2..8.
- `AW`, 16: address width.

- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cache_hit` in 1: cache holds the byte at `fetch_addr`; valid in the same cycle.
- `cache_data` in 8: byte at `fetch_addr`; valid when `cache_hit`=1.
- `flush` in 1: branch taken; redirect fetch.
- `flush_addr` in AW: branch target.
- `pop` in 1: decoder consumes the head byte this cycle.
- `fetch_addr` out AW: address presented to the cache.
- `fetch_req` out 1: combinational cache read request.
- `byte_out` out 8: head byte.
- `byte_pc` out AW: address of the head byte.
- `valid` out 1: queue not empty.
- `count` out 4: occupancy, 0..DEPTH.
- `pc_inc` out 1: one-cycle pulse per byte accepted into the queue.

## Operation
- **State machine: VEC_LO → VEC_HI → RUN.**
- **VEC_LO**
  - `fetch_addr`=0xFFFC, `fetch_req`=1.
  - On `cache_hit`: latch `cache_data` as the vector low byte and go to VEC_HI.
  - On a miss: hold.
- **VEC_HI**
  - `fetch_addr`=0xFFFD, `fetch_req`=1.
  - On `cache_hit`: `fetch_addr` <= {`cache_data`, low byte} and go to RUN.
  - Vector bytes are never pushed into the queue and never pulse `pc_inc`.
- **RUN, fetch**
  - `fetch_req` = (`count` < DEPTH) & ~`flush`.
  - On `fetch_req` & `cache_hit`: push {`cache_data`, `fetch_addr`} at the tail, `fetch_addr` <= `fetch_addr`+1, pulse `pc_inc`.
  - Address increment wraps modulo 2^AW (0xFFFF → 0x0000).
  - On a miss: no push; `fetch_addr` holds and is retried next cycle.
- **RUN, pop**
  - `pop` & `valid` advances the head pointer.
  - `pop` with `valid`=0 is ignored.
- **Simultaneous push and pop:** both happen; `count` is unchanged.
- **Full queue:** `fetch_req`=0 while `count`=DEPTH, even if `pop` is high that cycle (no bypass). Refill starts the next cycle.
- **Flush (any state, highest priority)**
  - Head, tail and `count` go to 0; `fetch_addr` <= `flush_addr`; state goes to RUN.
  - No push and no `pc_inc` that cycle; `pop` is ignored.
- **Reset values:** state VEC_LO, `fetch_addr`=0xFFFC, `count`=0, `valid`=0, `pc_inc`=0, head/tail=0, `byte_out`/`byte_pc`=0.
- **Reset is asynchronous and dominates.** Asserting `rst` mid-fetch drops `fetch_req` immediately, and the vector sequence restarts after release.
- **Output sourcing**
  - `byte_out`/`byte_pc` come from the head entry.
  - They are don't-care while `valid`=0 but must not be X after reset.

## Timing
- **`fetch_req`** is combinational from state, `count` and `flush`. It is 0 while `rst`=1 and 1 in the first cycle after release.
- **Push:** a byte pushed at edge N is visible on `byte_out` with `valid`=1 after edge N. Queue latency is 1 cycle.
- **`pc_inc`** is registered and high for the cycle after the push edge.
- **Best case after reset** (all hits):
  - Cycle 0: VEC_LO.
  - Cycle 1: VEC_HI.
  - Cycle 2: first RUN fetch.
  - Cycle 3: `valid`=1.
- **Flush:** the cycle after a flush edge has `valid`=0 and `fetch_addr`=`flush_addr`. The first redirected byte is valid 2 cycles after the flush edge if it hits.
- **Throughput:** one byte per cycle with continuous hits and continuous pops. `count` stays constant at steady state.
- **Miss stalls:** each miss cycle delays the stream by exactly one cycle.

## Test plan
- **Reset vector:** cache returns 0x34 @FFFC and 0x12 @FFFD, always hit.
  - `fetch_addr` sequence is FFFC, FFFD, 1234.
  - First `byte_pc`=0x1234 with `valid` high in cycle 3.
  - No `pc_inc` pulse for the vector bytes.
- **Fill to full:** DEPTH=4, `pop`=0, always hit from 0x1234.
  - `count` goes 1, 2, 3, 4, then `fetch_req`=0 and `fetch_addr` holds at 0x1238.
  - Four `pc_inc` pulses.
- **Streaming:** `pop`=1 continuously once `valid`.
  - `byte_pc` increments by 1 every cycle.
  - `count` stays at 1; no bytes lost or duplicated.
- **Wrap and miss:** vector 0xFFFE.
  - `cache_hit` low for 2 cycles at 0xFFFF.
  - `byte_pc` sequence is FFFE, FFFF, 0000; the FFFF byte is delayed by 2 cycles.
- **Flush mid-stream:** 3 entries queued; `flush`=1 with `flush_addr`=0x8000 and `pop`=1 in the same cycle.
  - Next cycle `count`=0, `valid`=0, `fetch_addr`=0x8000.
  - Next valid head has `byte_pc`=0x8000.
- **Reset mid-operation:** `rst` pulsed while RUN with 2 entries queued.
  - Outputs return to reset values asynchronously.
  - The vector fetch repeats from 0xFFFC.
